jtframe_i2s_rx: RTL and testbench

I2S receiver: the capture end of the serial audio link that the board-level I2S transmitter drives (BCLK/LRCLK/DATA). It runs entirely in the system clock domain and oversamples the three I2S pins. It deserializes MSB-first, one-bit-delayed I2S words into parallel signed left/right samples with a pair-valid strobe. It serves transmitter loopback checks and boards with an external I2S ADC.

---
 rtl/jtframe_i2s_rx.sv | 162 ++++++++++++++++
 tb/tb_jtframe_i2s_rx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_i2s_rx.sv
// jtframe_i2s_rx
// I2S receiver running entirely in the system clock domain. The three I2S
// pins are oversampled and the MSB-first, one-bit-delayed words are turned
// into parallel left/right samples.
//
// Parameters
//   DW    output sample width (first DW bits of each slot are kept)
//   TOUT  clk cycles without a BCLK rising edge before the link is dropped
// Ports
//   clk        system clock, at least 4x the BCLK frequency
//   rst        synchronous active-high reset
//   i2s_bclk   bit clock pin (asynchronous)
//   i2s_lrclk  word select pin (asynchronous), 0 = left, 1 = right
//   i2s_data   serial data pin (asynchronous)
//   snd_left   last complete left sample (two's complement)
//   snd_right  last complete right sample (two's complement)
//   sample     one-cycle strobe, a new left/right pair is valid
//   locked     link aligned and delivering samples
//   err        one-cycle strobe on a malformed slot
module jtframe_i2s_rx #(
  parameter int DW   = 16,
  parameter int TOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i2s_bclk,
  input  logic          i2s_lrclk,
  input  logic          i2s_data,
  output logic [DW-1:0] snd_left,
  output logic [DW-1:0] snd_right,
  output logic          sample,
  output logic          locked,
  output logic          err
);

  localparam logic ST_SYNC = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam int       TW  = $clog2(TOUT + 1);
  localparam logic [6:0] DW7 = 7'(DW);

  // Pin synchronizers; BCLK carries an extra history flop for edge detection
  logic bclk_s1, bclk_s2, bclk_s3;
  logic lr_s1, lr_s2;
  logic dat_s1, dat_s2;

  logic          state;
  logic          lr_q;       // channel owning the bit being received
  logic [5:0]    bit_cnt;    // bits already received in the current slot
  logic [DW-1:0] shreg;
  logic [DW-1:0] hold_l;
  logic          hold_vld;
  logic [TW-1:0] tout_cnt;

  logic          bre;
  logic          bnd;
  logic          keep;
  logic          short_slot;
  logic          ovf;
  logic          tout_hit;
  logic [6:0]    nbits;
  logic [6:0]    pad;
  logic [DW-1:0] shifted;
  logic [DW-1:0] word;

  always_comb begin
    bre        = bclk_s2 & ~bclk_s3;
    bnd        = lr_s2 ^ lr_q;
    keep       = {1'b0, bit_cnt} < DW7;
    nbits      = {1'b0, bit_cnt} + 7'd1;      // slot length including this bit
    short_slot = nbits < DW7;
    pad        = DW7 - nbits;
    shifted    = keep ? {shreg[DW-2:0], dat_s2} : shreg;
    // Short slots are left-justified so the sample keeps its full-scale meaning
    word       = short_slot ? (shifted << pad) : shifted;
    // A 33rd bit that is not a word boundary means the slot is too long
    ovf        = bit_cnt == 6'd32;
    tout_hit   = ~bre & (tout_cnt == TW'(TOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_s1   <= 1'b0;
      bclk_s2   <= 1'b0;
      bclk_s3   <= 1'b0;
      lr_s1     <= 1'b0;
      lr_s2     <= 1'b0;
      dat_s1    <= 1'b0;
      dat_s2    <= 1'b0;
      state     <= ST_SYNC;
      lr_q      <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      hold_l    <= '0;
      hold_vld  <= 1'b0;
      tout_cnt  <= '0;
      snd_left  <= '0;
      snd_right <= '0;
      sample    <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      bclk_s1 <= i2s_bclk;
      bclk_s2 <= bclk_s1;
      bclk_s3 <= bclk_s2;
      lr_s1   <= i2s_lrclk;
      lr_s2   <= lr_s1;
      dat_s1  <= i2s_data;
      dat_s2  <= dat_s1;
      sample  <= 1'b0;
      err     <= 1'b0;

      // Saturating idle counter, restarted by every BCLK rise
      if (bre)
        tout_cnt <= '0;
      else if (tout_cnt != TW'(TOUT))
        tout_cnt <= tout_cnt + 1'b1;

      if (tout_hit) begin
        // Lost link: outputs keep their last values, no error strobe
        state    <= ST_SYNC;
        locked   <= 1'b0;
        hold_vld <= 1'b0;
      end else if (bre) begin
        lr_q <= lr_s2;
        if (state == ST_SYNC) begin
          if (bnd) begin
            // The bit after a boundary is an MSB; start clean from there
            state    <= ST_RUN;
            bit_cnt  <= '0;
            shreg    <= '0;
            hold_vld <= 1'b0;
          end
        end else if (bnd) begin
          // This bit is the LSB of channel lr_q
          bit_cnt <= '0;
          shreg   <= '0;
          if (short_slot)
            err <= 1'b1;
          if (!lr_q) begin
            hold_l   <= word;
            hold_vld <= 1'b1;
          end else if (hold_vld) begin
            snd_left  <= hold_l;
            snd_right <= word;
            sample    <= 1'b1;
            locked    <= 1'b1;
          end
        end else if (ovf) begin
          err      <= 1'b1;
          state    <= ST_SYNC;
          locked   <= 1'b0;
          hold_vld <= 1'b0;
        end else begin
          shreg   <= shifted;
          bit_cnt <= bit_cnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtframe_i2s_rx.sv
// Testbench for jtframe_i2s_rx: drives I2S frames at BCLK = clk/8 and checks
// decoded pairs, error strobes and lock status against a slot-level model.
module tb_jtframe_i2s_rx;

  localparam int DW   = 16;
  localparam int TOUT = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bclk = 1'b0;
  logic          lrclk = 1'b0;
  logic          data = 1'b0;
  logic [DW-1:0] snd_left, snd_right;
  logic          sample, locked, err;

  jtframe_i2s_rx #(.DW(DW), .TOUT(TOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .i2s_bclk  (bclk),
    .i2s_lrclk (lrclk),
    .i2s_data  (data),
    .snd_left  (snd_left),
    .snd_right (snd_right),
    .sample    (sample),
    .locked    (locked),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor
  logic [2*DW-1:0] got_q[$];
  int got_err = 0;
  int last_sample_cyc = 0;
  always @(negedge clk) begin
    if (sample) begin
      got_q.push_back({snd_left, snd_right});
      last_sample_cyc = cyc;
    end
    if (err) got_err = got_err + 1;
  end

  int n_chk = 0;
  int n_fail = 0;
  int last_rlsb_cyc = 0;

  // Slot-level reference model
  bit              m_sync = 1'b1;
  bit              m_hv = 1'b0;
  logic [DW-1:0]   m_hold = '0;
  bit              m_locked = 1'b0;
  logic [2*DW-1:0] exp_q[$];
  int              exp_err = 0;

  int gb, eb, errb, xerrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_sync = 1'b1;
    m_hv = 1'b0;
    m_locked = 1'b0;
  endtask

  task automatic model_slot(input logic ch, input int len, input logic [63:0] val);
    logic [DW-1:0] w;
    if (m_sync) begin
      // first boundary seen since (re)start: slot content is discarded
      m_sync = 1'b0;
      m_hv = 1'b0;
    end else if (len > 32) begin
      exp_err++;
      m_locked = 1'b0;
      m_hv = 1'b0;
    end else begin
      if (len >= DW) w = DW'(val >> (len - DW));
      else begin
        w = DW'(val << (DW - len));
        exp_err++;
      end
      if (!ch) begin
        m_hold = w;
        m_hv = 1'b1;
      end else if (m_hv) begin
        exp_q.push_back({m_hold, w});
        m_locked = 1'b1;
      end
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, " snd_left"}, 64'(snd_left), 64'd0);
    chk({name, " snd_right"}, 64'(snd_right), 64'd0);
    chk({name, " sample"}, 64'(sample), 64'd0);
    chk({name, " locked"}, 64'(locked), 64'd0);
    chk({name, " err"}, 64'(err), 64'd0);
  endtask

  // One slot, MSB first; LRCLK switches to the next channel at the LSB
  task automatic send_slot(input logic ch, input int len, input logic [63:0] val, input int rst_at);
    for (int i = len - 1; i >= 0; i--) begin
      bclk = 1'b0;
      lrclk = (i == 0) ? ~ch : ch;
      data = val[i];
      tick(4);
      bclk = 1'b1;
      if (i == 0 && ch) last_rlsb_cyc = cyc;
      if (len - 1 - i == rst_at) begin
        rst = 1'b1;
        tick(1);
        check_zero("midword reset");
        rst = 1'b0;
        model_reset();
      end
      tick(4);
    end
    model_slot(ch, len, val);
  endtask

  task automatic send_frame(input int llen, input logic [63:0] lv, input int rlen, input logic [63:0] rv);
    send_slot(1'b0, llen, lv, -1);
    send_slot(1'b1, rlen, rv, -1);
  endtask

  task automatic do_reset();
    bclk = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(2);
  endtask

  task automatic mark();
    gb = got_q.size();
    eb = exp_q.size();
    errb = got_err;
    xerrb = exp_err;
  endtask

  task automatic compare_run(input string name, input bit do_err);
    int n_got, n_exp;
    n_got = got_q.size() - gb;
    n_exp = exp_q.size() - eb;
    chk({name, " pair count"}, 64'(n_got), 64'(n_exp));
    for (int i = 0; i < n_got && i < n_exp; i++)
      chk({name, " pair"}, 64'(got_q[gb + i]), 64'(exp_q[eb + i]));
    if (do_err) chk({name, " err count"}, 64'(got_err - errb), 64'(exp_err - xerrb));
    chk({name, " locked"}, 64'(locked), 64'(m_locked));
  endtask

  function automatic logic [63:0] rnd_val(input int len);
    logic [63:0] mask;
    mask = (64'd1 << len) - 64'd1;
    return {$urandom, $urandom} & mask;
  endfunction

  typedef struct {
    int          llen;
    logic [31:0] lv;
    int          rlen;
    logic [31:0] rv;
    logic [15:0] el;
    logic [15:0] er;
    int          eerr;
  } vec_t;

  vec_t vt[4];
  int   lens[6] = '{8, 12, 16, 20, 24, 32};

  initial begin
    logic [DW-1:0] sl, sr;
    vt[0] = '{16, 32'h1234,     16, 32'hABCD,     16'h1234, 16'hABCD, 0};
    vt[1] = '{32, 32'h8001FFFF, 32, 32'h7FFE0000, 16'h8001, 16'h7FFE, 0};
    vt[2] = '{12, 32'hABC,      12, 32'h123,      16'hABC0, 16'h1230, 5};
    vt[3] = '{16, 32'h5555,     16, 32'hAAAA,     16'h5555, 16'hAAAA, 0};

    tick(3);
    check_zero("reset state");
    rst = 1'b0;
    model_reset();
    tick(2);

    // Directed vectors: three frames from reset, first one absorbed by SYNC
    for (int v = 0; v < 4; v++) begin
      do_reset();
      mark();
      for (int f = 0; f < 3; f++)
        send_frame(vt[v].llen, 64'(vt[v].lv), vt[v].rlen, 64'(vt[v].rv));
      chk($sformatf("vec%0d pairs", v), 64'(got_q.size() - gb), 64'd2);
      for (int i = gb; i < got_q.size(); i++)
        chk($sformatf("vec%0d value", v), 64'(got_q[i]), 64'({vt[v].el, vt[v].er}));
      chk($sformatf("vec%0d err", v), 64'(got_err - errb), 64'(vt[v].eerr));
      chk($sformatf("vec%0d locked", v), 64'(locked), 64'd1);
      compare_run($sformatf("vec%0d model", v), 1'b1);
      if (v == 0)
        chk("latency", 64'(last_sample_cyc - last_rlsb_cyc), 64'd3);
    end

    // Random slot lengths and values against the model
    do_reset();
    mark();
    for (int f = 0; f < 25; f++) begin
      int ll, rl;
      ll = lens[$urandom_range(5, 0)];
      rl = lens[$urandom_range(5, 0)];
      send_frame(ll, rnd_val(ll), rl, rnd_val(rl));
    end
    compare_run("random", 1'b1);

    // Make sure the link is locked before the timeout test
    mark();
    send_frame(16, 64'h0F0F, 16, 64'hF0F0);
    send_frame(16, 64'h0F0F, 16, 64'hF0F0);
    compare_run("prelock", 1'b1);
    chk("pre-timeout locked", 64'(locked), 64'd1);

    // BCLK stalls: lock drops, outputs held, no strobes
    mark();
    sl = snd_left;
    sr = snd_right;
    bclk = 1'b0;
    tick(TOUT + 4);
    m_sync = 1'b1;
    m_locked = 1'b0;
    chk("timeout snd_left held", 64'(snd_left), 64'(sl));
    chk("timeout snd_right held", 64'(snd_right), 64'(sr));
    compare_run("timeout", 1'b1);
    mark();
    send_frame(16, 64'h5555, 16, 64'hAAAA);
    send_frame(16, 64'h5555, 16, 64'hAAAA);
    compare_run("resume", 1'b1);
    chk("resume value", 64'(got_q[got_q.size() - 1]), 64'h5555AAAA);

    // LRCLK stuck low for 40 bits: overflow error, then relock
    mark();
    send_slot(1'b0, 40, rnd_val(40), -1);
    compare_run("overflow", 1'b1);
    mark();
    send_slot(1'b1, 16, rnd_val(16), -1);
    send_frame(16, 64'h1357, 16, 64'h2468);
    compare_run("relock", 1'b1);

    // Reset in the middle of a right word
    mark();
    send_slot(1'b0, 16, 64'h4321, -1);
    send_slot(1'b1, 16, 64'h8765, 8);
    chk("no sample after reset", 64'(got_q.size() - gb), 64'd0);
    send_frame(16, 64'h1111, 16, 64'h2222);
    compare_run("after reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
